// File: rtl/serial_chain_driver.sv
// Serial configuration chain master: shifts a parallel word LSB-first into the
// chain, strobes update, and captures the chain's previous contents as readback.
`ifndef DATA_LEN
`define DATA_LEN 8
`endif

module serial_chain_driver #(
  parameter int unsigned DATA_LEN = `DATA_LEN
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [DATA_LEN-1:0] tx_data,
  input  logic                tx_valid,
  output logic                tx_ready,
  output logic                chain_data,
  output logic                chain_enable,
  output logic                chain_update,
  input  logic                chain_return,
  output logic [DATA_LEN-1:0] rx_data,
  output logic                rx_valid,
  output logic                busy
);

  localparam int unsigned        CNT_W = $clog2(DATA_LEN) + 1;
  localparam logic [CNT_W-1:0]   LAST  = CNT_W'(DATA_LEN - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_UPDATE
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [DATA_LEN-1:0] r_tx_shreg;
  logic [DATA_LEN-1:0] r_rx_shreg;
  logic [DATA_LEN-1:0] r_rx_data;
  logic [DATA_LEN-1:0] w_rx_shift;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_rx_valid;
  logic                w_accept;

  assign w_accept = tx_valid && (r_state == S_IDLE);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (w_accept) w_state_nxt = S_SHIFT;
      S_SHIFT:  if (r_cnt == LAST) w_state_nxt = S_UPDATE;
      S_UPDATE: w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // Written as shift-then-overwrite so DATA_LEN=1 needs no zero-width slice.
  always_comb begin
    w_rx_shift                = r_rx_shreg >> 1;
    w_rx_shift[DATA_LEN-1]    = chain_return;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_tx_shreg <= '0;
      r_rx_shreg <= '0;
      r_rx_data  <= '0;
      r_cnt      <= '0;
      r_rx_valid <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_rx_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_tx_shreg <= tx_data;
            r_cnt      <= '0;
          end
        end
        S_SHIFT: begin
          r_tx_shreg <= r_tx_shreg >> 1;
          r_rx_shreg <= w_rx_shift;
          r_cnt      <= r_cnt + CNT_W'(1);
        end
        S_UPDATE: begin
          r_rx_data  <= r_rx_shreg;
          r_rx_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // The shift register empties to zero after a full transfer, so its LSB is
  // already 0 during UPDATE and IDLE.
  assign chain_data   = r_tx_shreg[0];
  assign chain_enable = (r_state == S_SHIFT);
  assign chain_update = (r_state == S_UPDATE);
  assign tx_ready     = (r_state == S_IDLE);
  assign busy         = (r_state != S_IDLE);
  assign rx_data      = r_rx_data;
  assign rx_valid     = r_rx_valid;

endmodule

// File: tb/tb_serial_chain_driver.sv
// Bench for serial_chain_driver: 8-bit and 1-bit instances driving behavioural
// chain models, with a scoreboard of expected readback / chain outputs.
module tb_serial_chain_driver;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  int         cyc = 0;

  logic [7:0] tx_data = '0;
  logic       tx_valid = 1'b0;
  logic       tx_ready, chain_data, chain_enable, chain_update, chain_return;
  logic [7:0] rx_data;
  logic       rx_valid, busy;

  logic [0:0] tx_data1 = '0;
  logic       tx_valid1 = 1'b0;
  logic       tx_ready1, chain_data1, chain_enable1, chain_update1, chain_return1;
  logic [0:0] rx_data1;
  logic       rx_valid1, busy1;

  serial_chain_driver #(.DATA_LEN(8)) u_dut (
    .clk(clk), .reset(rst_n), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .chain_data(chain_data), .chain_enable(chain_enable),
    .chain_update(chain_update), .chain_return(chain_return),
    .rx_data(rx_data), .rx_valid(rx_valid), .busy(busy)
  );

  serial_chain_driver #(.DATA_LEN(1)) u_dut1 (
    .clk(clk), .reset(rst_n), .tx_data(tx_data1), .tx_valid(tx_valid1),
    .tx_ready(tx_ready1), .chain_data(chain_data1), .chain_enable(chain_enable1),
    .chain_update(chain_update1), .chain_return(chain_return1),
    .rx_data(rx_data1), .rx_valid(rx_valid1), .busy(busy1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural chains: cell N-1 receives chain_data, cell 0 returns.
  logic [7:0] cells = 8'h00, par = 8'h00;
  logic [0:0] cells1 = '0, par1 = '0;
  always @(posedge clk) begin
    if (chain_enable) cells <= {chain_data, cells[7:1]};
    if (chain_update) par <= cells;
    if (chain_enable1) cells1 <= chain_data1;
    if (chain_update1) par1 <= cells1;
  end
  assign chain_return  = cells[0];
  assign chain_return1 = cells1[0];

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Scoreboard entry: {expected rx_data, expected chain parallel out}.
  logic [15:0] exp_q[$];
  int          acc_q[$];
  int          en_cnt = 0;
  int          upd_cnt = 0;
  int          rxv_cnt = 0;
  logic        prev_rxv = 1'b0;
  logic [7:0]  cap = '0, last_cap = '0;

  always @(negedge clk) begin
    if (!rst_n) begin
      acc_q.delete();
      en_cnt   = 0;
      prev_rxv = 1'b0;
    end else begin
      check_eq("strobe_excl", 32'(chain_enable & chain_update), 32'd0);
      if (chain_enable) begin
        check_eq("ready_in_shift", 32'(tx_ready), 32'd0);
        cap[en_cnt % 8] = chain_data;
        en_cnt++;
      end
      if (chain_update) begin
        upd_cnt++;
        check_eq("enable_len", 32'(en_cnt), 32'd8);
        check_eq("update_cdata", 32'(chain_data), 32'd0);
        last_cap = cap;
        en_cnt   = 0;
      end
      if (tx_valid && tx_ready) acc_q.push_back(cyc);
      if (rx_valid) begin
        logic [15:0] e;
        int          a;
        rxv_cnt++;
        check_eq("ready_at_rxv", 32'(tx_ready), 32'd1);
        check_eq("sb_nonempty", 32'(exp_q.size() > 0 && acc_q.size() > 0), 32'd1);
        if (exp_q.size() > 0 && acc_q.size() > 0) begin
          e = exp_q.pop_front();
          a = acc_q.pop_front();
          check_eq("rx_data", 32'(rx_data), 32'(e[15:8]));
          check_eq("chain_par", 32'(par), 32'(e[7:0]));
          check_eq("rx_latency", 32'(cyc - a), 32'd10);
        end
      end
      check_eq("rxv_pulse", 32'(prev_rxv & rx_valid), 32'd0);
      prev_rxv = rx_valid;
    end
  end

  task automatic send(input logic [7:0] d, input logic [7:0] erx);
    int n = 0;
    exp_q.push_back({erx, d});
    @(negedge clk);
    tx_data  = d;
    tx_valid = 1'b1;
    while (!tx_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check_eq("ready_timeout", 32'(tx_ready), 32'd1);
    @(posedge clk);
    #1;
    tx_valid = 1'b0;
    tx_data  = 8'($urandom);
  endtask

  task automatic wait_rx(input int target);
    int n = 0;
    while (rxv_cnt < target && n < 60) begin
      @(negedge clk);
      n++;
    end
    check_eq("rx_timeout", 32'(rxv_cnt >= target), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int u0, a1, a2, n, en1, up1;

    #2;
    check_eq("rst_ready", 32'(tx_ready), 32'd1);
    check_eq("rst_outs", 32'({chain_data, chain_enable, chain_update, rx_valid, busy}), 32'd0);
    check_eq("rst_rx_data", 32'(rx_data), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    send(8'hA5, 8'h00);
    wait_rx(1);
    check_eq("cdata_seq", 32'(last_cap), 32'hA5);

    send(8'h3C, 8'hA5);
    wait_rx(2);

    // Back-to-back with tx_valid held high across both accepts.
    exp_q.push_back({8'h3C, 8'h01});
    exp_q.push_back({8'h01, 8'h80});
    @(negedge clk);
    tx_data  = 8'h01;
    tx_valid = 1'b1;
    check_eq("b2b_ready0", 32'(tx_ready), 32'd1);
    a1 = cyc;
    @(posedge clk);
    #1 tx_data = 8'h80;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!tx_ready && n < 40);
    a2 = cyc;
    check_eq("b2b_period", 32'(a2 - a1), 32'd10);
    check_eq("b2b_rxv", 32'(rx_valid), 32'd1);
    @(posedge clk);
    #1 tx_valid = 1'b0;
    wait_rx(4);

    // Inputs wiggling while busy must not disturb the captured word.
    send(8'h66, 8'h80);
    repeat (9) begin
      tx_valid = 1'($urandom_range(0, 1));
      tx_data  = 8'($urandom);
      check_eq("hold_ready", 32'(tx_ready), 32'd0);
      @(posedge clk);
      #1;
    end
    tx_valid = 1'b0;
    wait_rx(5);

    send(8'h12, 8'h66);
    wait_rx(6);

    // Abort 0xFF after four shifts.
    u0 = upd_cnt;
    @(negedge clk);
    tx_data  = 8'hFF;
    tx_valid = 1'b1;
    @(posedge clk);
    #1 tx_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check_eq("abort_outs", 32'({chain_data, chain_enable, chain_update, rx_valid, busy}), 32'd0);
    check_eq("abort_ready", 32'(tx_ready), 32'd1);
    check_eq("abort_rx_data", 32'(rx_data), 32'd0);
    check_eq("abort_cells", 32'(cells), 32'hF1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    check_eq("abort_par", 32'(par), 32'h12);
    check_eq("abort_no_upd", 32'(upd_cnt - u0), 32'd0);

    send(8'h55, 8'hF1);
    wait_rx(7);
    check_eq("sb_drained", 32'(exp_q.size()), 32'd0);

    // Single-cell chain.
    @(negedge clk);
    tx_data1  = 1'b1;
    tx_valid1 = 1'b1;
    check_eq("len1_ready", 32'(tx_ready1), 32'd1);
    @(posedge clk);
    #1 tx_valid1 = 1'b0;
    n = 0; en1 = 0; up1 = 0;
    do begin
      @(negedge clk);
      n++;
      if (chain_enable1) en1++;
      if (chain_update1) up1++;
    end while (!rx_valid1 && n < 20);
    check_eq("len1_latency", 32'(n), 32'd3);
    check_eq("len1_enables", 32'(en1), 32'd1);
    check_eq("len1_updates", 32'(up1), 32'd1);
    check_eq("len1_par", 32'(par1), 32'd1);
    check_eq("len1_rx_data", 32'(rx_data1), 32'd0);

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/serial_chain_driver.md
Name: serial_chain_driver

Overview:
- Transmit-side master for the serial configuration chain: accepts a parallel word over a valid/ready handshake and shifts it LSB-first into the chain's serial input with a shift enable.
- Issues a single update strobe after the last shift so the chain transfers the word to its parallel outputs.
- Simultaneously captures the chain's serial return, so the previous chain contents are read back as a parallel word.
- Sits between the control logic (or host bridge) and the chain of register cells.

Parameters:
- DATA_LEN, default `DATA_LEN (global define), chain length in bits; must be >= 1 and equal to the attached chain length.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- tx_data  in  DATA_LEN  word to write; bit i lands in chain cell i.
- tx_valid  in  1  tx_data is valid.
- tx_ready  out  1  driver can accept a word.
- chain_data  out  1  serial data to the chain input (the cell DATA_LEN-1 end).
- chain_enable  out  1  chain shift enable.
- chain_update  out  1  chain update strobe, copies chain contents to parallel outputs.
- chain_return  in  1  serial data from the chain output (cell 0).
- rx_data  out  DATA_LEN  readback word; bit i = previous content of cell i.
- rx_valid  out  1  one-cycle pulse, rx_data updated.
- busy  out  1  transfer in progress (state != IDLE).

Behaviour:
- FSM states:
  - IDLE: tx_ready=1. On tx_valid && tx_ready, load tx_shreg <= tx_data, clear bit counter, go to SHIFT.
  - SHIFT: chain_enable=1 for exactly DATA_LEN consecutive cycles. chain_data = tx_shreg[0], driven from a register. Each cycle:
    - tx_shreg shifts right by 1.
    - rx_shreg <= {chain_return, rx_shreg[DATA_LEN-1:1]}.
    - Counter increments; when counter == DATA_LEN-1, go to UPDATE.
  - UPDATE: exactly one cycle. chain_update=1, chain_enable=0, chain_data=0. Then rx_data <= rx_shreg, rx_valid pulses, go to IDLE.
- Sampling: chain_return is sampled on the same edge that shifts the chain. In shift cycle k (k=0..DATA_LEN-1) it carries the old cell k.
- Timing: handshake in cycle 0; SHIFT in cycles 1..DATA_LEN; UPDATE in cycle DATA_LEN+1.
  - In cycle DATA_LEN+2: rx_valid=1, rx_data valid, tx_ready=1.
  - Back-to-back accept is allowed in that cycle, so the accept-to-accept period is DATA_LEN+2.
- Strobe exclusivity: chain_enable and chain_update are never both high. Both are low in IDLE.
- Input hold rules:
  - tx_data and tx_valid are ignored while busy.
  - tx_data may change after acceptance.
  - rx_data holds its value until the next UPDATE completes.
- Counter width: $clog2(DATA_LEN)+1. DATA_LEN=1 gives one SHIFT cycle and then UPDATE.
- Reset values (asynchronous, while reset=0):
  - State IDLE; tx_ready=1.
  - chain_data, chain_enable, chain_update, rx_valid, busy = 0.
  - rx_data, tx_shreg, rx_shreg, counter = 0.
- Reset mid-transfer: the transfer is aborted immediately and no update is issued, so the chain's parallel outputs keep their prior value. The partially shifted chain is overwritten by the next full transfer.

Test Plan:
- DATA_LEN=8, bench chain model preloaded with 0x00. Apply tx_data=0xA5 -> chain_enable high for exactly 8 cycles; chain_data sequence 1,0,1,0,0,1,0,1; one update pulse; chain parallel out = 0xA5; rx_data=0x00 with a 1-cycle rx_valid at cycle 10.
- Follow with tx_data=0x3C -> chain parallel out = 0x3C; rx_data=0xA5.
- Back-to-back: hold tx_valid high with 0x01 then 0x80 -> second accept in the same cycle as the first rx_valid; 10-cycle period; final chain out = 0x80, rx_data=0x01.
- tx_valid toggling and tx_data changing during SHIFT -> no effect; tx_ready=0 throughout; transferred word equals the value captured at acceptance.
- Assert reset at shift cycle 4 of 0xFF over a chain holding 0x12 -> outputs immediately at reset values, no chain_update, chain parallel out stays 0x12. After release, 0x55 transfers normally with rx_data = partially shifted chain contents.
- DATA_LEN=1: tx_data=1 -> one enable cycle, update, rx_valid in cycle 3; chain out = 1.
